oled_frame_sequencer: RTL and testbench
=======================================

// Module: oled_frame_sequencer
// PURPOSE
//  Upstream byte sequencer for the SSD1306 I2C master. After reset it waits a
//  power-up delay, sends the fixed SSD1306 init command list, sets the full-screen
//  address window, then streams one 128x64 frame (1024 bytes) from a framebuffer
//  read port. Further frames are sent on request. Drives start/DCn/Data; paces on busy.
// PARAMETERS
//  PWRUP_CYCLES  2400000  clk cycles of idle after reset before first byte (100 ms @ 24 MHz)
//  FB_BYTES      1024     data bytes per frame; fb_addr counts 0..FB_BYTES-1
// PORTS
//  clk         in   1   system clock; all logic on posedge
//  rst_n       in   1   asynchronous active-low reset
//  refresh     in   1   1-cycle pulse: request a frame transfer
//  fb_addr     out  10  framebuffer read address
//  fb_data     in   8   framebuffer byte; valid 1 cycle after fb_addr changes
//  i2c_start   out  1   1-cycle start pulse to I2C master
//  i2c_dcn     out  1   0 = command byte, 1 = display data byte
//  i2c_data    out  8   byte to transmit; held stable from start until busy falls
//  i2c_busy    in   1   I2C master busy
//  ready       out  1   1 when init done and no frame in progress
//  frame_done  out  1   1-cycle pulse after last data byte's busy falls
// BEHAVIOUR
//  Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
//  Reset values: fb_addr=0, i2c_start=0, i2c_dcn=0, i2c_data=0, ready=0,
//   frame_done=0; state=PWRUP; pwrup counter=0; pending=0; byte index=0.
//  Init ROM (25 cmds, in order): AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA
//   12 81 CF D9 F1 DB 40 A4 A6 AF. Window list (6 cmds): 21 00 7F 22 00 07.
//  States: PWRUP -> INIT -> WIN -> FETCH -> DATA -> IDLE; byte send via
//   SEND -> WAIT_HI -> WAIT_LO sub-sequence, then return to calling phase.
//  PWRUP: count PWRUP_CYCLES cycles, then also wait until i2c_busy=0 (master has
//   no reset and may still be finishing a byte), then enter INIT.
//  Byte send: present i2c_data/i2c_dcn, assert i2c_start for exactly 1 cycle,
//   deassert; WAIT_HI until i2c_busy=1; WAIT_LO until i2c_busy=0; advance index.
//   i2c_start is never asserted while i2c_busy=1. No timeout.
//  INIT: 25 bytes, dcn=0. WIN: 6 bytes, dcn=0. Then the first frame is sent
//   automatically, without waiting for refresh.
//  FETCH: drive fb_addr=index, wait 1 cycle, capture fb_data into i2c_data.
//  DATA: send captured byte with dcn=1; index 0..FB_BYTES-1, no wrap within a
//   frame. After last byte: frame_done=1 for one cycle, index=0, fb_addr=0, -> IDLE.
//  Every frame (auto or refresh) is preceded by the WIN list so the GDDRAM
//   pointer is re-homed to (0,0).
//  ready=1 only in IDLE. In IDLE, refresh (or pending=1) -> WIN; pending cleared.
//  refresh outside IDLE (PWRUP/INIT/WIN/DATA) sets pending=1; multiple requests
//   merge into one frame. refresh in the same cycle as frame_done is latched.
//  Reset mid-operation: all state returns to reset values immediately; sequence
//   restarts from PWRUP; partial frame discarded.
// TESTING (PWRUP_CYCLES=16; I2C master model: busy rises 1 cycle after start,
//   falls N cycles later)
//  Release rst_n -> no i2c_start for 16 cycles; first byte 0xAE dcn=0; 25 init +
//   6 window cmds in listed order; then 1024 dcn=1 bytes; frame_done pulses once.
//  fb memory[i]=i[7:0] -> data bytes observed 00,01..FF,00.. matching fb_addr 0..1023.
//  Hold i2c_busy=1 at reset release for 40 cycles -> first start only after busy=0.
//  Pulse refresh 3 times during frame -> exactly one extra frame (6 cmds+1024 bytes).
//  Pulse refresh in IDLE -> ready falls next cycle; next byte 0x21 dcn=0.
//  Assert rst_n=0 mid-frame at byte 500 -> outputs reset; restart shows 0xAE first.

Source files
------------

// File: rtl/oled_frame_sequencer.sv
// Byte sequencer feeding an SSD1306 I2C master: power-up delay, init command list,
// address window, then full framebuffer frames on demand.
module oled_frame_sequencer #(
    parameter int unsigned PWRUP_CYCLES = 2400000,
    parameter int unsigned FB_BYTES     = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       refresh,
    output logic [9:0] fb_addr,
    input  logic [7:0] fb_data,
    output logic       i2c_start,
    output logic       i2c_dcn,
    output logic [7:0] i2c_data,
    input  logic       i2c_busy,
    output logic       ready,
    output logic       frame_done
);

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned CNT_W    = (PWRUP_CYCLES > 0) ? $clog2(PWRUP_CYCLES + 1) : 1;
    localparam int unsigned INIT_LEN = 25;
    localparam int unsigned WIN_LEN  = 6;

    typedef enum logic [3:0] {
        S_PWRUP,
        S_INIT,
        S_WIN,
        S_FETCH,
        S_FWAIT,
        S_CAPT,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO,
        S_IDLE
    } state_e;

    typedef enum logic [1:0] {
        PH_INIT,
        PH_WIN,
        PH_DATA
    } phase_e;

    state_e              state_q, state_d;
    phase_e              phase_q, phase_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                pending_q, pending_d;
    logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic                start_q, start_d;
    logic                dcn_q, dcn_d;
    logic [7:0]          data_q, data_d;
    logic                ready_q, ready_d;
    logic                frame_done_q, frame_done_d;

    // SSD1306 power-on configuration sequence
    function automatic logic [7:0] init_byte(input logic [4:0] i);
        logic [7:0] b;
        case (i)
            5'd0:    b = 8'hAE;
            5'd1:    b = 8'hD5;
            5'd2:    b = 8'h80;
            5'd3:    b = 8'hA8;
            5'd4:    b = 8'h3F;
            5'd5:    b = 8'hD3;
            5'd6:    b = 8'h00;
            5'd7:    b = 8'h40;
            5'd8:    b = 8'h8D;
            5'd9:    b = 8'h14;
            5'd10:   b = 8'h20;
            5'd11:   b = 8'h00;
            5'd12:   b = 8'hA1;
            5'd13:   b = 8'hC8;
            5'd14:   b = 8'hDA;
            5'd15:   b = 8'h12;
            5'd16:   b = 8'h81;
            5'd17:   b = 8'hCF;
            5'd18:   b = 8'hD9;
            5'd19:   b = 8'hF1;
            5'd20:   b = 8'hDB;
            5'd21:   b = 8'h40;
            5'd22:   b = 8'hA4;
            5'd23:   b = 8'hA6;
            5'd24:   b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Full-screen column/page window; re-homes the GDDRAM pointer to (0,0)
    function automatic logic [7:0] win_byte(input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = 8'h21;
            3'd1:    b = 8'h00;
            3'd2:    b = 8'h7F;
            3'd3:    b = 8'h22;
            3'd4:    b = 8'h00;
            3'd5:    b = 8'h07;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_PWRUP;
            phase_q      <= PH_INIT;
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            fb_addr_q    <= '0;
            start_q      <= 1'b0;
            dcn_q        <= 1'b0;
            data_q       <= '0;
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            fb_addr_q    <= fb_addr_d;
            start_q      <= start_d;
            dcn_q        <= dcn_d;
            data_q       <= data_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        fb_addr_d    = fb_addr_q;
        start_d      = 1'b0;
        dcn_d        = dcn_q;
        data_d       = data_q;
        frame_done_d = 1'b0;

        if (refresh && (state_q != S_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            // The master has no reset, so also wait for any in-flight byte to finish
            S_PWRUP: begin
                if (cnt_q != CNT_W'(PWRUP_CYCLES)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!i2c_busy) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (!i2c_busy) begin
                    data_d  = init_byte(idx_q[4:0]);
                    dcn_d   = 1'b0;
                    start_d = 1'b1;
                    phase_d = PH_INIT;
                    state_d = S_SEND;
                end
            end
            S_WIN: begin
                if (!i2c_busy) begin
                    data_d  = win_byte(idx_q[2:0]);
                    dcn_d   = 1'b0;
                    start_d = 1'b1;
                    phase_d = PH_WIN;
                    state_d = S_SEND;
                end
            end
            S_FETCH: begin
                fb_addr_d = idx_q;
                state_d   = S_FWAIT;
            end
            S_FWAIT: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                if (!i2c_busy) begin
                    data_d  = fb_data;
                    dcn_d   = 1'b1;
                    start_d = 1'b1;
                    phase_d = PH_DATA;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (i2c_busy) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!i2c_busy) begin
                    case (phase_q)
                        PH_INIT: begin
                            if (idx_q == ADDR_W'(INIT_LEN - 1)) begin
                                idx_d   = '0;
                                state_d = S_WIN;
                            end else begin
                                idx_d   = idx_q + ADDR_W'(1);
                                state_d = S_INIT;
                            end
                        end
                        PH_WIN: begin
                            if (idx_q == ADDR_W'(WIN_LEN - 1)) begin
                                idx_d   = '0;
                                state_d = S_FETCH;
                            end else begin
                                idx_d   = idx_q + ADDR_W'(1);
                                state_d = S_WIN;
                            end
                        end
                        default: begin
                            if (idx_q == ADDR_W'(FB_BYTES - 1)) begin
                                idx_d        = '0;
                                fb_addr_d    = '0;
                                frame_done_d = 1'b1;
                                state_d      = S_IDLE;
                            end else begin
                                idx_d   = idx_q + ADDR_W'(1);
                                state_d = S_FETCH;
                            end
                        end
                    endcase
                end
            end
            S_IDLE: begin
                if (refresh || pending_q) begin
                    pending_d = 1'b0;
                    idx_d     = '0;
                    state_d   = S_WIN;
                end
            end
            default: begin
                state_d = S_PWRUP;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    assign fb_addr    = fb_addr_q;
    assign i2c_start  = start_q;
    assign i2c_dcn    = dcn_q;
    assign i2c_data   = data_q;
    assign ready      = ready_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Bench for oled_frame_sequencer: I2C master and framebuffer models, byte-stream
// scoreboard built from the command lists and framebuffer contents.
module tb_oled_frame_sequencer;

    localparam int unsigned PW = 16;
    localparam int unsigned FB = 1024;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       refresh;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;
    logic       i2c_start;
    logic       i2c_dcn;
    logic [7:0] i2c_data;
    logic       i2c_busy;
    logic       ready;
    logic       frame_done;

    always #5 clk = ~clk;

    oled_frame_sequencer #(.PWRUP_CYCLES(PW), .FB_BYTES(FB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .refresh    (refresh),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .i2c_start  (i2c_start),
        .i2c_dcn    (i2c_dcn),
        .i2c_data   (i2c_data),
        .i2c_busy   (i2c_busy),
        .ready      (ready),
        .frame_done (frame_done)
    );

    // Synchronous-read framebuffer
    logic [7:0] mem [FB];
    always @(posedge clk) fb_data <= mem[fb_addr];

    // I2C master: busy rises the cycle after start, stays high 1..3 cycles
    logic m_busy = 1'b0;
    int   m_cnt  = 0;
    logic force_busy = 1'b0;
    assign i2c_busy = m_busy | force_busy;
    always @(posedge clk) begin
        if (m_busy) begin
            if (m_cnt <= 1) m_busy <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end else if (i2c_start) begin
            m_busy <= 1'b1;
            m_cnt  <= int'($urandom_range(3, 1));
        end
    end

    // Bus monitor: records every transmitted byte and protocol violations
    logic [8:0] byte_q[$];
    int         addr_q[$];
    int         viol = 0;
    int         done_cnt = 0;
    logic       prev_start = 1'b0;
    logic       in_byte = 1'b0;
    logic [7:0] held = 8'h00;
    always @(posedge clk) begin
        prev_start <= i2c_start;
        if (frame_done) done_cnt++;
        if (!rst_n) begin
            in_byte <= 1'b0;
        end else if (i2c_start) begin
            if (i2c_busy || prev_start) viol++;
            byte_q.push_back({i2c_dcn, i2c_data});
            if (i2c_dcn) addr_q.push_back(int'(fb_addr));
            in_byte <= 1'b1;
            held    <= i2c_data;
        end else if (in_byte && i2c_busy && (i2c_data !== held)) begin
            viol++;
        end
    end

    logic [7:0] init_list [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                   8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                                   8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
                                   8'hAF};
    logic [7:0] win_list [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
    logic [8:0] exp_q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_exp(input bit with_init);
        exp_q.delete();
        if (with_init) foreach (init_list[i]) exp_q.push_back({1'b0, init_list[i]});
        foreach (win_list[i]) exp_q.push_back({1'b0, win_list[i]});
        for (int a = 0; a < int'(FB); a++) exp_q.push_back({1'b1, mem[a]});
    endtask

    task automatic cmp_frame(input string tag);
        int bad = 0;
        int abad = 0;
        int n;
        chk({tag, "_len"}, byte_q.size(), exp_q.size());
        n = (byte_q.size() < exp_q.size()) ? byte_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (byte_q[i] !== exp_q[i]) bad++;
        chk({tag, "_bytes_bad"}, bad, 0);
        chk({tag, "_addr_len"}, addr_q.size(), FB);
        foreach (addr_q[i]) if (addr_q[i] != i) abad++;
        chk({tag, "_addr_bad"}, abad, 0);
    endtask

    task automatic wait_done(input int target);
        int c = 0;
        while (done_cnt < target && c < 20000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("frame_done_timeout", 32'(done_cnt >= target), 1);
    endtask

    task automatic wait_bytes(input int n);
        int c = 0;
        while (addr_q.size() < n && c < 20000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("data_bytes_timeout", 32'(addr_q.size() >= n), 1);
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        @(posedge clk); #1;
        refresh = 1'b0;
    endtask

    function automatic logic [8:0] first_byte();
        return (byte_q.size() > 0) ? byte_q[0] : 9'h1FF;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_fb_addr"}, fb_addr, 0);
        chk({tag, "_start"}, i2c_start, 0);
        chk({tag, "_dcn"}, i2c_dcn, 0);
        chk({tag, "_data"}, i2c_data, 0);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    initial begin
        int d0;
        rst_n   = 1'b0;
        refresh = 1'b0;
        for (int a = 0; a < int'(FB); a++) mem[a] = 8'(a);

        // Reset values and power-up silence
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (PW) @(posedge clk);
        #1;
        chk("pwrup_no_start", byte_q.size(), 0);
        chk("pwrup_ready", ready, 0);

        // First frame is automatic: init + window + counting-pattern data
        build_exp(1'b1);
        wait_done(1);
        cmp_frame("frame1");
        chk("frame1_first", first_byte(), {1'b0, 8'hAE});
        repeat (50) @(posedge clk);
        #1;
        chk("frame1_done_once", done_cnt, 1);
        chk("idle_ready", ready, 1);
        chk("idle_fb_addr", fb_addr, 0);
        chk("idle_no_more_bytes", byte_q.size(), 31 + FB);

        // Refresh in IDLE, then three merged refreshes mid-frame
        for (int a = 0; a < int'(FB); a++) mem[a] = 8'($urandom);
        byte_q.delete();
        addr_q.delete();
        pulse_refresh();
        chk("refresh_ready_fall", ready, 0);
        build_exp(1'b0);
        wait_bytes(200);
        for (int k = 0; k < 3; k++) begin
            pulse_refresh();
            repeat (7) @(posedge clk);
            #1;
        end
        wait_done(2);
        cmp_frame("frame2");
        chk("frame2_first", first_byte(), {1'b0, 8'h21});
        byte_q.delete();
        addr_q.delete();
        wait_done(3);
        cmp_frame("frame3");
        repeat (100) @(posedge clk);
        #1;
        chk("merged_one_extra_frame", byte_q.size(), 6 + FB);
        chk("merged_done_cnt", done_cnt, 3);
        chk("merged_ready", ready, 1);

        // Reset mid-frame with a pending request; master held busy after release
        for (int a = 0; a < int'(FB); a++) mem[a] = 8'($urandom);
        byte_q.delete();
        addr_q.delete();
        pulse_refresh();
        wait_bytes(100);
        pulse_refresh();
        wait_bytes(500);
        rst_n      = 1'b0;
        force_busy = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        d0 = done_cnt;
        byte_q.delete();
        addr_q.delete();
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("busy_hold_no_start", byte_q.size(), 0);
        force_busy = 1'b0;
        build_exp(1'b1);
        wait_done(d0 + 1);
        cmp_frame("restart");
        chk("restart_first", first_byte(), {1'b0, 8'hAE});
        repeat (100) @(posedge clk);
        #1;
        chk("restart_pending_cleared", byte_q.size(), 31 + FB);
        chk("restart_done_cnt", done_cnt, d0 + 1);

        chk("protocol_violations", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
